// File: rtl/aes128_package.sv
// ---------------------------------------------------------------------------
// aes128_package
// Shared constants and helpers for the masked-AES randomness path.
//   rng_state_e     : control states of masked_rand_gen
//   LFSR_TAPS       : feedback taps of the 64-bit Fibonacci LFSR
//                     (bits 63, 62, 60, 59)
//   LFSR_SEED_SUBST : value loaded instead of an all-zero seed, which would
//                     lock the LFSR up
//   num_quad()      : number of fresh random elements a masked multiplier
//                     with the given share count consumes per operation
// ---------------------------------------------------------------------------
package aes128_package;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } rng_state_e;

  localparam logic [63:0] LFSR_TAPS       = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LFSR_SEED_SUBST = 64'h0000_0000_0000_0001;

  // One fresh element per unordered pair of shares.
  function automatic int num_quad(input int num_shares);
    return (num_shares * (num_shares - 1)) / 2;
  endfunction

endpackage

// File: rtl/lfsr_multistep.sv
// ---------------------------------------------------------------------------
// lfsr_multistep
// Combinational STEPS-fold unrolling of a 64-bit Fibonacci LFSR.
// One step: fb = ^(s & TAPS); s' = {s[62:0], fb}.
//   state_i : current LFSR state
//   state_o : state after STEPS single steps
// ---------------------------------------------------------------------------
module lfsr_multistep
  import aes128_package::*;
#(
  parameter int          STEPS = 1,
  parameter logic [63:0] TAPS  = LFSR_TAPS
) (
  input  logic [63:0] state_i,
  output logic [63:0] state_o
);

  if (STEPS < 1) begin : g_bad_steps
    $error("lfsr_multistep: STEPS must be at least 1");
  end

  // Each stage owns its own nets so the chain is not one self-feeding array.
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    logic [63:0] cur;
    logic [63:0] nxt;
    if (gi == 0) begin : g_first
      assign cur = state_i;
    end else begin : g_rest
      assign cur = g_step[gi-1].nxt;
    end
    assign nxt = {cur[62:0], ^(cur & TAPS)};
  end

  assign state_o = g_step[STEPS-1].nxt;

endmodule

// File: rtl/shared_reg.sv
// ---------------------------------------------------------------------------
// shared_reg
// Generic D register with asynchronous active-low reset.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous reset, active low; loads RESET_VAL
//   d_i    : next value
//   q_o    : registered value
// ---------------------------------------------------------------------------
module shared_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RESET_VAL;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/masked_rand_gen.sv
// ---------------------------------------------------------------------------
// masked_rand_gen
// LFSR-based source of fresh randomness for a masked multiplier.
// After a seed handshake the LFSR warms up for WARMUP_CYCLES advances, then
// presents one word per cycle; the consumer advances it with in_enable.
// Each advance applies OUT_W single LFSR steps so consecutive words share
// no state bits.
//   in_clock       : clock, rising edge
//   in_reset       : asynchronous reset, active low
//   in_seed        : 64-bit seed (zero is replaced by 64'h1)
//   in_seed_valid  : seed offered
//   out_seed_ready : seed accepted when high with in_seed_valid (low in WARMUP)
//   in_enable      : consumer takes the current word (honoured in RUN only)
//   out_valid      : out_r/out_p carry fresh randomness
//   out_r          : blinding randomness, NQ elements of BIT_WIDTH
//   out_p          : correction randomness, same packing
// Build option: define MASKED_RAND_GEN_ZERO_RAND_EN to tie out_r/out_p to
// zero in all states; control and handshake behaviour is unchanged.
// ---------------------------------------------------------------------------
module masked_rand_gen
  import aes128_package::*;
#(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 1,
  parameter int WARMUP_CYCLES = 4,
  localparam int NQ    = num_quad(NUM_SHARES),
  localparam int R_W   = NQ * BIT_WIDTH,
  localparam int OUT_W = 2 * R_W
) (
  input  logic           in_clock,
  input  logic           in_reset,
  input  logic [63:0]    in_seed,
  input  logic           in_seed_valid,
  output logic           out_seed_ready,
  input  logic           in_enable,
  output logic           out_valid,
  output logic [R_W-1:0] out_r,
  output logic [R_W-1:0] out_p
);

  localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);

  if (OUT_W > 64) begin : g_bad_width
    $error("masked_rand_gen: OUT_W exceeds the 64-bit LFSR state");
  end
  if (WARMUP_CYCLES < 1) begin : g_bad_warmup
    $error("masked_rand_gen: WARMUP_CYCLES must be at least 1");
  end

  rng_state_e       state_q, state_d;
  logic [1:0]       state_raw_q;
  logic [63:0]      s_q, s_d, s_adv;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seed_take;

  shared_reg #(.WIDTH(2), .RESET_VAL(IDLE)) u_state_reg (
    .clk_i (in_clock),
    .rst_ni(in_reset),
    .d_i   (state_d),
    .q_o   (state_raw_q)
  );
  assign state_q = rng_state_e'(state_raw_q);

  shared_reg #(.WIDTH(64), .RESET_VAL(LFSR_SEED_SUBST)) u_lfsr_reg (
    .clk_i (in_clock),
    .rst_ni(in_reset),
    .d_i   (s_d),
    .q_o   (s_q)
  );

  shared_reg #(.WIDTH(CNT_W), .RESET_VAL('0)) u_cnt_reg (
    .clk_i (in_clock),
    .rst_ni(in_reset),
    .d_i   (cnt_d),
    .q_o   (cnt_q)
  );

  lfsr_multistep #(.STEPS(OUT_W), .TAPS(LFSR_TAPS)) u_step (
    .state_i(s_q),
    .state_o(s_adv)
  );

  assign out_seed_ready = (state_q != WARMUP);
  assign out_valid      = (state_q == RUN);
  assign seed_take      = in_seed_valid && out_seed_ready;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (seed_take) begin
          s_d     = (in_seed == 64'h0) ? LFSR_SEED_SUBST : in_seed;
          cnt_d   = '0;
          state_d = WARMUP;
        end
      end
      WARMUP: begin
        s_d   = s_adv;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A new seed wins over a same-cycle advance.
        if (seed_take) begin
          s_d     = (in_seed == 64'h0) ? LFSR_SEED_SUBST : in_seed;
          cnt_d   = '0;
          state_d = WARMUP;
        end else if (in_enable) begin
          s_d = s_adv;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MASKED_RAND_GEN_ZERO_RAND_EN
  assign out_r = '0;
  assign out_p = '0;
`else
  assign out_r = out_valid ? s_q[R_W-1:0]     : '0;
  assign out_p = out_valid ? s_q[OUT_W-1:R_W] : '0;
`endif

endmodule

// File: tb/tb_masked_rand_gen.sv
module tb_masked_rand_gen;

  localparam int NS = 2;
  localparam int BW = 1;
  localparam int WU = 1;
  localparam int NQ = NS * (NS - 1) / 2;
  localparam int RW = NQ * BW;
  localparam int OW = 2 * RW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [63:0]   seed = 64'h0;
  logic          seed_valid = 1'b0;
  logic          enable = 1'b0;
  logic          seed_ready;
  logic          valid;
  logic [RW-1:0] r;
  logic [RW-1:0] p;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = warmup, 2 = run
  int            m_mode = 0;
  int            m_cnt  = 0;
  logic [63:0]   m_s    = 64'h1;

  typedef struct packed {
    logic          v;
    logic          rdy;
    logic [OW-1:0] w;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  masked_rand_gen #(
    .NUM_SHARES   (NS),
    .BIT_WIDTH    (BW),
    .WARMUP_CYCLES(WU)
  ) dut (
    .in_clock      (clk),
    .in_reset      (rst_n),
    .in_seed       (seed),
    .in_seed_valid (seed_valid),
    .out_seed_ready(seed_ready),
    .in_enable     (enable),
    .out_valid     (valid),
    .out_r         (r),
    .out_p         (p)
  );

  function automatic logic [63:0] step1(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [63:0] adv(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < OW; i++) t = step1(t);
    return t;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.v   = (m_mode == 2);
    e.rdy = (m_mode != 1);
`ifdef MASKED_RAND_GEN_ZERO_RAND_EN
    e.w   = '0;
`else
    e.w   = e.v ? m_s[OW-1:0] : '0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, "/valid"}, 64'(valid), 64'(e.v));
    chk({tag, "/ready"}, 64'(seed_ready), 64'(e.rdy));
    chk({tag, "/word"}, 64'({p, r}), 64'(e.w));
  endtask

  // Drive one cycle, update the model for the coming edge, push the
  // expectation, then pop and compare it against the DUT after the edge.
  task automatic drive(input string tag, input logic sv, input logic [63:0] sd, input logic en);
    exp_t e;
    seed_valid = sv;
    seed       = sd;
    enable     = en;
    if (sv && m_mode != 1) begin
      m_s    = (sd == 64'h0) ? 64'h1 : sd;
      m_cnt  = 0;
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_s = adv(m_s);
      m_cnt++;
      if (m_cnt == WU) m_mode = 2;
    end else if (m_mode == 2 && en) begin
      m_s = adv(m_s);
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "/queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk_outputs(tag, e);
    end
    $display("%s: sv=%0b en=%0b valid=%0b ready=%0b r=%h p=%h", tag, sv, en, valid, seed_ready, r, p);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic pulse_reset(input string tag);
    seed_valid = 1'b0;
    enable     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    m_mode = 0;
    m_cnt  = 0;
    m_s    = 64'h1;
    chk_outputs({tag, "/async"}, model_out());
    $display("%s: reset asserted valid=%0b ready=%0b r=%h p=%h", tag, valid, seed_ready, r, p);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Async reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk_outputs("reset_async", model_out());
    $display("reset_async: valid=%0b ready=%0b r=%h p=%h", valid, seed_ready, r, p);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle for 20 cycles; enable must be ignored.
    for (int i = 0; i < 20; i++) drive("idle", 1'b0, 64'h0, (i % 2) == 1);

    // Seed 1, warmup, then 1000 enabled cycles.
    drive("seed1", 1'b1, 64'h1, 1'b0);
    for (int i = 0; i < WU; i++) drive("seed1_warm", 1'b0, 64'h0, 1'b1);
`ifndef MASKED_RAND_GEN_ZERO_RAND_EN
    chk("seed1_first_word", 64'({p, r}), 64'h0);
`endif
    for (int i = 0; i < 1000; i++) drive("run", 1'b0, 64'h0, 1'b1);

    // Reseed with zero: must behave as seed 1.
    drive("seed0", 1'b1, 64'h0, 1'b0);
    for (int i = 0; i < WU; i++) drive("seed0_warm", 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 50; i++) drive("seed0_run", 1'b0, 64'h0, 1'b1);

    // Enable pattern 1,0,0,1.
    drive("en_1a", 1'b0, 64'h0, 1'b1);
    drive("en_0a", 1'b0, 64'h0, 1'b0);
    drive("en_0b", 1'b0, 64'h0, 1'b0);
    drive("en_1b", 1'b0, 64'h0, 1'b1);

    // Reseed with enable high; a seed offered during warmup is ignored.
    drive("reseed_en", 1'b1, 64'hDEAD_BEEF_1234_5678, 1'b1);
    for (int i = 0; i < WU; i++) drive("reseed_warm", 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    for (int i = 0; i < 40; i++) drive("reseed_run", 1'b0, 64'h0, 1'b1);

    // Reset during warmup: seed discarded.
    drive("seed_a", 1'b1, 64'hA5A5_5A5A_C3C3_3C3C, 1'b0);
    pulse_reset("rst_warm");
    for (int i = 0; i < 5; i++) drive("after_rst_warm", 1'b0, 64'h0, 1'b1);

    // Reset during run: outputs cleared at once, seed discarded.
    drive("seed_b", 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
    for (int i = 0; i < WU + 3; i++) drive("seed_b_run", 1'b0, 64'h0, 1'b1);
    pulse_reset("rst_run");
    for (int i = 0; i < 5; i++) drive("after_rst_run", 1'b0, 64'h0, 1'b1);

    // Fresh seed 1 after reset: same timing as the first run.
    drive("seed1_again", 1'b1, 64'h1, 1'b0);
    for (int i = 0; i < WU; i++) drive("seed1_again_warm", 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 30; i++) drive("seed1_again_run", 1'b0, 64'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/masked_rand_gen.md
MASKED_RAND_GEN -- requirements
Module: masked_rand_gen

Interface
REQ-001 Parameter NUM_SHARES, default 2: share count of the downstream masked multiplier.
REQ-002 Parameter BIT_WIDTH, default 1: element width of the downstream masked multiplier.
REQ-003 Parameter WARMUP_CYCLES, default 4: number of state-advance cycles after each seed load before output is valid; SHALL be at least 1.
REQ-004 Derived constants: NQ = num_quad(NUM_SHARES); R_W = NQ*BIT_WIDTH; OUT_W = 2*R_W; elaboration SHALL fail if OUT_W > 64.
REQ-005 in_clock  input  1  sole clock; all flops on its rising edge.
REQ-006 in_reset  input  1  asynchronous, active-low reset.
REQ-007 in_seed  input  64  seed value.
REQ-008 in_seed_valid  input  1  seed offered this cycle.
REQ-009 out_seed_ready  output  1  seed accepted when high together with in_seed_valid.
REQ-010 in_enable  input  1  consumer takes the current word; the generator advances.
REQ-011 out_valid  output  1  out_r/out_p carry fresh randomness.
REQ-012 out_r  output  R_W  blinding randomness, packed as NQ elements of BIT_WIDTH (multiplier in_r order).
REQ-013 out_p  output  R_W  correction randomness, same packing (multiplier in_p order).

Function
REQ-014 State is a 64-bit Fibonacci LFSR s; single step: fb = s[63]^s[62]^s[60]^s[59], s' = {s[62:0], fb}.
REQ-015 One "advance" SHALL apply exactly OUT_W single steps in one cycle (unrolled).
REQ-016 Output word w = s[OUT_W-1:0] of the registered state; out_r = w[R_W-1:0], out_p = w[OUT_W-1:R_W].
REQ-017 FSM states IDLE, WARMUP, RUN; reset state IDLE.
REQ-018 out_seed_ready SHALL be 1 in IDLE and RUN, 0 in WARMUP.
REQ-019 Seed handshake (valid & ready): s <= in_seed, or 64'h1 if in_seed == 0; warmup counter <= 0; next state WARMUP.
REQ-020 WARMUP: advance every cycle; counter increments; after WARMUP_CYCLES advances the next state is RUN.
REQ-021 Seed accepted at edge t -> out_valid first high after edge t+WARMUP_CYCLES.
REQ-022 RUN: out_valid = 1; advance only when in_enable = 1; with in_enable = 0, out_r/out_p SHALL hold stable.
REQ-023 Reseed in RUN SHALL take priority over advance in the same cycle; out_valid drops the following cycle.
REQ-024 out_r and out_p SHALL be driven to zero whenever out_valid = 0.
REQ-025 in_enable SHALL be ignored outside RUN; in_seed_valid SHALL be ignored in WARMUP.

Reset
REQ-026 in_reset low SHALL immediately force: FSM IDLE, s = 64'h1, counter = 0, out_valid = 0, out_r = out_p = 0, out_seed_ready = 1.
REQ-027 Reset asserted mid-WARMUP or mid-RUN SHALL discard the seed; a new seed handshake is required after release.

Configuration
REQ-028 Macro MASKED_RAND_GEN_ZERO_RAND_EN: when defined, out_r and out_p SHALL be constant zero in all states; FSM, handshake and out_valid are unchanged; when undefined, behaviour is REQ-014..REQ-025.

Structure
REQ-029 The LFSR tap constant and seed-substitute constant (64'h1) SHALL live in aes128_package; num_quad is reused from it.
REQ-030 The unrolled OUT_W-step update SHALL be a combinational sub-module lfsr_multistep (parameters STEPS, taps from package).
REQ-031 State and FSM registers SHALL use the shared register module, adapted for asynchronous active-low reset.

Verification
REQ-032 Reset release, no seed -> out_valid = 0, out_r = out_p = 0, out_seed_ready = 1 for 20 cycles.
REQ-033 NUM_SHARES=2, BIT_WIDTH=1, WARMUP_CYCLES=1, seed 64'h1 at edge t -> s = 64'h4 after edge t+1, out_valid = 1, out_r = 0, out_p = 0; matches the golden model for the next 1000 enabled cycles.
REQ-034 Seed 64'h0 -> output sequence identical to seed 64'h1.
REQ-035 RUN with in_enable toggled 1,0,0,1 -> word held across both disabled cycles; exactly two advances occur.
REQ-036 Reseed in RUN with in_enable = 1 in the same cycle -> state equals the new seed (no advance), out_valid = 0 for WARMUP_CYCLES cycles, out_seed_ready = 0 throughout WARMUP.
REQ-037 in_reset pulsed low mid-WARMUP -> IDLE at once, all outputs zero; with MASKED_RAND_GEN_ZERO_RAND_EN defined, out_valid timing matches REQ-033 and out_r = out_p = 0.
